// File: rtl/bram_read_scheduler_if.sv
// Request, BRAM read-port and tagged word-stream signals of the BRAM read scheduler.
// slave is the scheduler side; master is the requester/BRAM/consumer side.
interface bram_read_scheduler_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [ADDR_W-1:0] req0_base;
    logic [ADDR_W-1:0] req1_base;
    logic [ADDR_W-1:0] req0_len;
    logic [ADDR_W-1:0] req1_len;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_id;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              busy;

    modport slave (
        input  req0_valid, req1_valid, req0_base, req1_base, req0_len, req1_len, bram_dout,
        output req0_ready, req1_ready, bram_en, bram_addr,
        output out_valid, out_data, out_id, out_idx, out_last, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_base, req1_base, req0_len, req1_len, bram_dout,
        input  req0_ready, req1_ready, bram_en, bram_addr,
        input  out_valid, out_data, out_id, out_idx, out_last, busy
    );
endinterface

// File: rtl/bram_read_scheduler.sv
// Two-requester round-robin BRAM burst read scheduler; streams each burst's words
// tagged with requester id and index, one word per cycle after a one-cycle read latency.
module bram_read_scheduler #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    bram_read_scheduler_if.slave bus
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_grant_r;
    logic              id_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx_r;
    logic              out_valid_r;
    logic              out_id_r;
    logic              out_last_r;
    logic [ADDR_W-1:0] out_idx_r;

    logic              grant0_s;
    logic              grant1_s;
    logic              accept_s;
    logic              accept_id_s;
    logic [ADDR_W-1:0] accept_base_s;
    logic [ADDR_W-1:0] accept_len_s;
    logic              last_word_s;

    // Round-robin grant; ready is forced low while reset is asserted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == IDLE) && rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0_s = 1'b1;
            end else if (bus.req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
        accept_s      = grant0_s | grant1_s;
        accept_id_s   = grant1_s;
        accept_base_s = grant1_s ? bus.req1_base : bus.req0_base;
        accept_len_s  = grant1_s ? bus.req1_len : bus.req0_len;
        last_word_s   = (idx_r == (len_r - ONE_ADDR));
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (accept_len_s != ZERO_ADDR)) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (last_word_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst context, address walk and output tag pipeline (tags trail the address by one cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            addr_r       <= ZERO_ADDR;
            len_r        <= ZERO_ADDR;
            idx_r        <= ZERO_ADDR;
            out_valid_r  <= 1'b0;
            out_id_r     <= 1'b0;
            out_last_r   <= 1'b0;
            out_idx_r    <= ZERO_ADDR;
        end else begin
            if (accept_s) begin
                last_grant_r <= accept_id_s;
            end
            if (accept_s && (accept_len_s != ZERO_ADDR)) begin
                id_r   <= accept_id_s;
                addr_r <= accept_base_s;
                len_r  <= accept_len_s;
                idx_r  <= ZERO_ADDR;
            end else if ((state_r == READ) && !last_word_s) begin
                addr_r <= addr_r + ONE_ADDR;
                idx_r  <= idx_r + ONE_ADDR;
            end
            out_valid_r <= (state_r == READ);
            out_last_r  <= (state_r == READ) && last_word_s;
            if (state_r == READ) begin
                out_idx_r <= idx_r;
                out_id_r  <= id_r;
            end
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.bram_en    = (state_r == READ);
    assign bus.bram_addr  = addr_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_valid_r ? bus.bram_dout : {DATA_W{1'b0}};
    assign bus.out_id     = out_id_r;
    assign bus.out_idx    = out_idx_r;
    assign bus.out_last   = out_last_r;
    assign bus.busy       = (state_r != IDLE);
endmodule

// File: tb/tb_bram_read_scheduler.sv
// Directed and random bench for bram_read_scheduler; expected behaviour comes from a
// per-cycle schedule of reads/words built from each accepted burst.
module tb_bram_read_scheduler;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NSLOT = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_read_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    bram_read_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Synchronous-read BRAM model.
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
    end

    // Expected per-cycle schedule
    bit            exp_en   [NSLOT];
    logic [AW-1:0] exp_addr [NSLOT];
    bit            exp_ov   [NSLOT];
    logic [DW-1:0] exp_data [NSLOT];
    bit            exp_id   [NSLOT];
    logic [AW-1:0] exp_idx  [NSLOT];
    bit            exp_last [NSLOT];
    bit            exp_busy [NSLOT];

    int            cyc = 0;
    int            free_at = 0;
    int            last_id = 1;
    logic [AW-1:0] held_addr = '0;
    int            obs_acc = -1;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_slot(input int k);
        if (k < NSLOT) begin
            exp_en[k] = 0; exp_addr[k] = '0; exp_ov[k] = 0; exp_data[k] = '0;
            exp_id[k] = 0; exp_idx[k] = '0; exp_last[k] = 0; exp_busy[k] = 0;
        end
    endtask

    task automatic step(input logic v0, input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                        input logic v1, input logic [AW-1:0] b1, input logic [AW-1:0] l1,
                        input logic rst);
        int            win;
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [AW-1:0] a;
        @(negedge clk);
        rst_n = rst;
        bus.req0_valid = v0; bus.req0_base = b0; bus.req0_len = l0;
        bus.req1_valid = v1; bus.req1_base = b1; bus.req1_len = l1;
        #1;
        win = -1;
        if (!rst) begin
            for (int k = cyc; k < cyc + 64; k++) clear_slot(k);
            free_at = cyc + 1;
            last_id = 1;
            held_addr = '0;
        end else if ((cyc >= free_at) && (v0 || v1)) begin
            if (v0 && v1) win = (last_id == 1) ? 0 : 1;
            else          win = v0 ? 0 : 1;
        end
        if (exp_en[cyc]) held_addr = exp_addr[cyc];
        chk("req0_ready", bus.req0_ready, win == 0);
        chk("req1_ready", bus.req1_ready, win == 1);
        chk("bram_en", bus.bram_en, exp_en[cyc]);
        chk("bram_addr", bus.bram_addr, held_addr);
        chk("busy", bus.busy, exp_busy[cyc]);
        chk("out_valid", bus.out_valid, exp_ov[cyc]);
        chk("out_last", bus.out_last, exp_last[cyc]);
        if (exp_ov[cyc] || !rst) begin
            chk("out_data", bus.out_data, exp_data[cyc]);
            chk("out_id", bus.out_id, exp_id[cyc]);
            chk("out_idx", bus.out_idx, exp_idx[cyc]);
        end
        obs_acc = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
        if (win >= 0) begin
            base = (win == 1) ? b1 : b0;
            len  = (win == 1) ? l1 : l0;
            last_id = win;
            if (len == '0) begin
                free_at = cyc + 1;
            end else begin
                for (int k = 0; k < int'(len); k++) begin
                    a = base + AW'(k);
                    exp_en[cyc+1+k]   = 1;
                    exp_addr[cyc+1+k] = a;
                    exp_ov[cyc+2+k]   = 1;
                    exp_data[cyc+2+k] = mem[a];
                    exp_id[cyc+2+k]   = (win == 1);
                    exp_idx[cyc+2+k]  = AW'(k);
                    exp_last[cyc+2+k] = (k == int'(len) - 1);
                end
                for (int k = 1; k <= int'(len) + 1; k++) exp_busy[cyc+k] = 1;
                free_at = cyc + int'(len) + 2;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic issue(input int which, input logic [AW-1:0] b, input logic [AW-1:0] l);
        int n = 0;
        do begin
            step(which == 0, b, l, which == 1, b, l, 1'b1);
            n++;
        end while ((obs_acc != which) && (n < 50));
        chk("issue_accepted", obs_acc == which, 1'b1);
        idle(int'(l) + 2);
    endtask

    int q[$];
    int cnt;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_base = '0; bus.req1_base = '0; bus.req0_len = '0; bus.req1_len = '0;

        // Reset with requests pending: ready must stay low
        repeat (3) step(1'b1, 11'h005, 11'd3, 1'b1, 11'h006, 11'd3, 1'b0);

        // Contention straight out of reset, both len 2: order 0,1,0,1
        q.delete();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 11'h100, 11'd2, 1'b1, 11'h200, 11'd2, 1'b1);
            if (obs_acc >= 0) q.push_back(obs_acc);
        end
        chk("rr_count", q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < q.size()) chk("rr_order", q[i], i % 2);
        idle(4);

        // Basic len-4 burst with word = address
        issue(0, 11'h010, 11'd4);
        // Zero-length burst
        issue(1, 11'h123, 11'd0);
        idle(2);
        // Address wrap
        issue(0, 11'h7FE, 11'd4);

        // Reset at T+3 of a len-8 burst, then contention must go to req0
        issue(0, 11'h040, 11'd0);
        do step(1'b1, 11'h300, 11'd8, 1'b0, '0, '0, 1'b1); while (obs_acc != 0 && cyc < 500);
        idle(2);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        idle(3);
        step(1'b1, 11'h020, 11'd1, 1'b1, 11'h030, 11'd1, 1'b1);
        chk("post_rst_winner", bus.req0_ready, 1'b1);
        idle(4);

        // Continuous req0 with len 1: accepted every third cycle
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, AW'($urandom), 11'd1, 1'b0, '0, '0, 1'b1);
            if (obs_acc == 0) cnt++;
        end
        chk("len1_accepts", cnt, 4);
        idle(4);

        // Random traffic over random memory contents
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, AW'($urandom),
                 ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 24)) : AW'($urandom_range(0, 5)),
                 $urandom_range(0, 2) != 0, AW'($urandom),
                 ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 24)) : AW'($urandom_range(0, 5)),
                 1'b1);
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
